// File: rtl/wm8731_i2c_target_if.sv
// Register-side view of the WM8731 control-port target: shadow read port
// plus the commit notification and status flags.
interface wm8731_i2c_target_if;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       reg_wr;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  logic       nack_err;

  // Consumer of the register file (bench or self-test logic)
  modport master (
    output rd_addr,
    input  rd_data, reg_wr, reg_addr, reg_data, busy, nack_err
  );

  // The target itself
  modport slave (
    input  rd_addr,
    output rd_data, reg_wr, reg_addr, reg_data, busy, nack_err
  );
endinterface

// File: rtl/wm8731_i2c_target.sv
// WM8731 2-wire control-port target: accepts 3-byte write packets,
// ACKs them and mirrors the codec register file in a shadow copy.
module wm8731_i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i2c_sclk,
  inout  wire                       i2c_sdat,
  wm8731_i2c_target_if.slave        regs
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP
  } state_t;

  // Power-on / R15 reset contents of the codec register file
  function automatic logic [8:0] reg_default(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: reg_default = 9'h097;
      4'd2, 4'd3: reg_default = 9'h079;
      4'd4:       reg_default = 9'h00A;
      4'd5:       reg_default = 9'h008;
      4'd6:       reg_default = 9'h09F;
      4'd7:       reg_default = 9'h00A;
      default:    reg_default = 9'h000;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] byte1, byte1_n;
  logic       ack_drive, ack_drive_n;
  logic [7:0] byte_in;
  logic       commit, nack_set;
  logic [6:0] commit_addr;
  logic [8:0] commit_data;

  logic [8:0] shadow [0:10];
  logic       reg_wr_q, nack_q;
  logic [6:0] reg_addr_q;
  logic [8:0] reg_data_q;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Bring the bus lines into the clk domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sdat};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_in     = {shift[6:0], sda_s};
  assign commit_addr = byte1[7:1];
  assign commit_data = {byte1[0], byte_in};

  // Protocol state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      byte1     <= 8'h00;
      ack_drive <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      byte1     <= byte1_n;
      ack_drive <= ack_drive_n;
    end
  end

  // Next-state decode: START/STOP override everything, bits shift in on SCL rise,
  // ACK slots are framed by two SCL falling edges
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    byte1_n     = byte1;
    ack_drive_n = ack_drive;
    commit      = 1'b0;
    nack_set    = 1'b0;
    if (stop_det) begin
      state_n     = IDLE;
      bit_cnt_n   = 3'd0;
      ack_drive_n = 1'b0;
    end else if (start_det) begin
      state_n     = ADDR;
      bit_cnt_n   = 3'd0;
      ack_drive_n = 1'b0;
    end else begin
      if (scl_rise) begin
        shift_n   = byte_in;
        bit_cnt_n = bit_cnt + 3'd1;
      end
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt == 3'd7) begin
            if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
              state_n = ACK_A;
            end else begin
              nack_set = 1'b1;
              state_n  = WAIT_STOP;
            end
          end
        end
        BYTE1: begin
          if (scl_rise && bit_cnt == 3'd7) begin
            byte1_n = byte_in;
            state_n = ACK_1;
          end
        end
        BYTE2: begin
          if (scl_rise && bit_cnt == 3'd7) begin
            commit  = 1'b1;
            state_n = ACK_2;
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall) begin
            if (!ack_drive) begin
              ack_drive_n = 1'b1;
            end else begin
              ack_drive_n = 1'b0;
              bit_cnt_n   = 3'd0;
              if (state == ACK_A)      state_n = BYTE1;
              else if (state == ACK_1) state_n = BYTE2;
              else                     state_n = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: begin
          if (scl_rise && bit_cnt == 3'd7) nack_set = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Commit a decoded packet into the shadow file and latch the notification outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 11; i++) shadow[i] <= reg_default(4'(i));
      reg_wr_q   <= 1'b0;
      reg_addr_q <= 7'd0;
      reg_data_q <= 9'd0;
      nack_q     <= 1'b0;
    end else begin
      reg_wr_q <= commit;
      if (commit) begin
        reg_addr_q <= commit_addr;
        reg_data_q <= commit_data;
        if (commit_addr == 7'd15) begin
          for (int i = 0; i < 11; i++) shadow[i] <= reg_default(4'(i));
        end else if (commit_addr <= 7'd10) begin
          shadow[commit_addr[3:0]] <= commit_data;
        end
      end
      if (commit && commit_addr == 7'd15) nack_q <= 1'b0;
      else if (nack_set)                  nack_q <= 1'b1;
    end
  end

  assign i2c_sdat      = ack_drive ? 1'b0 : 1'bz;
  assign regs.rd_data  = (regs.rd_addr <= 4'd10) ? shadow[regs.rd_addr] : 9'h000;
  assign regs.reg_wr   = reg_wr_q;
  assign regs.reg_addr = reg_addr_q;
  assign regs.reg_data = reg_data_q;
  assign regs.busy     = (state != IDLE);
  assign regs.nack_err = nack_q;

endmodule

// File: tb/tb_wm8731_i2c_target.sv
// Self-checking bench for wm8731_i2c_target: bit-banged I2C master,
// register-file reference model, directed scenarios plus random packets.
`timescale 1ns/1ps
module tb_wm8731_i2c_target;

  logic clk = 1'b0;
  logic reset;
  logic scl;
  logic tb_low;
  wire  sda;

  int assert_count = 0;
  int fail_count   = 0;
  int q;
  int wr_count = 0;
  int dut_low  = 0;
  logic [8:0] pre_commit_rd;

  logic [8:0] model [16];
  logic       model_nack;
  int         model_wr;
  logic [6:0] exp_addr;
  logic [8:0] exp_data;

  wm8731_i2c_target_if regs_if();

  assign sda = tb_low ? 1'b0 : 1'bz;
  pullup (sda);

  wm8731_i2c_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .i2c_sclk (scl),
    .i2c_sdat (sda),
    .regs     (regs_if)
  );

  always #10 clk = ~clk;

  // Count reg_wr high cycles and cycles where the target pulls SDA low
  always begin
    @(negedge clk);
    #1;
    if (regs_if.reg_wr) wr_count++;
    if (!tb_low && sda === 1'b0) dut_low++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] default_of(input int i);
    case (i)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      7:       return 9'h00A;
      default: return 9'h000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = default_of(i);
    model_nack = 1'b0;
  endtask

  // Only R0..R10 hold data; R15 restores defaults; everything else is accepted but dropped
  task automatic model_write(input logic [6:0] a, input logic [8:0] d);
    model_wr++;
    exp_addr = a;
    exp_data = d;
    if (a == 7'd15) model_reset();
    else if (a < 7'd11) model[a] = d;
  endtask

  task automatic wait_q();
    repeat (q) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_low = 1'b0; wait_q();
    scl = 1'b1;    wait_q();
    tb_low = 1'b1; wait_q();
    scl = 1'b0;    wait_q();
  endtask

  task automatic i2c_stop();
    tb_low = 1'b1; wait_q();
    scl = 1'b1;    wait_q();
    tb_low = 1'b0; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      tb_low = !b[i]; wait_q();
      scl = 1'b1; wait_q(); wait_q();
      scl = 1'b0; wait_q();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_wr, output bit acked);
    bit saw;
    logic [8:0] prev;
    for (int i = 7; i >= 0; i--) begin
      tb_low = !b[i]; wait_q();
      scl = 1'b1;
      if (i == 0 && expect_wr) begin
        saw  = 1'b0;
        prev = regs_if.rd_data;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk); #1;
          if (regs_if.reg_wr && !saw) begin
            saw = 1'b1;
            pre_commit_rd = prev;
          end
          prev = regs_if.rd_data;
        end
        repeat (2 * q - 4) @(negedge clk);
        checkOutput("commit_latency", 32'(saw), 32'd1);
      end else begin
        wait_q(); wait_q();
      end
      scl = 1'b0; wait_q();
    end
    tb_low = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    acked = (sda === 1'b0);
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic applyStimulus(input logic [6:0] a, input logic [8:0] d, input bit extra);
    bit a0, a1, a2, a3;
    i2c_start();
    checkOutput("busy_after_start", 32'(regs_if.busy), 32'd1);
    send_byte(8'h34, 1'b0, a0);
    send_byte({a, d[8]}, 1'b0, a1);
    send_byte(d[7:0], 1'b1, a2);
    model_write(a, d);
    checkOutput("ack_dev", 32'(a0), 32'd1);
    checkOutput("ack_b1", 32'(a1), 32'd1);
    checkOutput("ack_b2", 32'(a2), 32'd1);
    if (extra) begin
      send_byte(8'($urandom), 1'b0, a3);
      checkOutput("extra_byte_nack", 32'(a3), 32'd0);
      model_nack = 1'b1;
    end
    i2c_stop();
  endtask

  task automatic bad_packet(input logic [7:0] dev, input bit with_data);
    bit ak;
    int low0;
    low0 = dut_low;
    i2c_start();
    send_byte(dev, 1'b0, ak);
    checkOutput("bad_dev_nack", 32'(ak), 32'd0);
    if (with_data) begin
      send_byte(8'($urandom), 1'b0, ak);
      send_byte(8'($urandom), 1'b0, ak);
      checkOutput("bad_data_nack", 32'(ak), 32'd0);
    end
    i2c_stop();
    checkOutput("bad_sda_never_low", 32'(dut_low - low0), 32'd0);
    model_nack = 1'b1;
  endtask

  task automatic check_all(input string ctx);
    checkOutput({ctx, "_wr_count"}, 32'(wr_count), 32'(model_wr));
    checkOutput({ctx, "_nack_err"}, 32'(regs_if.nack_err), 32'(model_nack));
    checkOutput({ctx, "_busy"}, 32'(regs_if.busy), 32'd0);
    checkOutput({ctx, "_sda_released"}, 32'(sda === 1'b1), 32'd1);
    checkOutput({ctx, "_reg_addr"}, 32'(regs_if.reg_addr), 32'(exp_addr));
    checkOutput({ctx, "_reg_data"}, 32'(regs_if.reg_data), 32'(exp_data));
    for (int i = 0; i < 16; i++) begin
      regs_if.rd_addr = 4'(i);
      @(negedge clk); #1;
      checkOutput($sformatf("%s_rd%0d", ctx, i), 32'(regs_if.rd_data), 32'(model[i]));
    end
  endtask

  initial begin
    bit ak;
    int kind;
    logic [6:0] a;
    logic [8:0] d;
    logic [7:0] dev;

    reset = 1'b0; scl = 1'b1; tb_low = 1'b0; q = 4;
    regs_if.rd_addr = 4'd0;
    model_reset(); model_wr = 0; exp_addr = 7'd0; exp_data = 9'd0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_reg_wr", 32'(regs_if.reg_wr), 32'd0);
    check_all("reset");

    // R4 = 0x012 at 100 kHz, with rd_addr parked on 4 to observe the collision
    q = 125;
    regs_if.rd_addr = 4'd4;
    applyStimulus(7'd4, 9'h012, 1'b0);
    checkOutput("collision_old_value", 32'(pre_commit_rd), 32'h00A);
    check_all("r4");

    q = 4;
    applyStimulus(7'd0, 9'h17F, 1'b0);
    check_all("r0");
    bad_packet(8'h36, 1'b1);
    check_all("wrong_addr");
    bad_packet(8'h35, 1'b0);
    check_all("read_req");
    applyStimulus(7'd15, 9'h000, 1'b0);
    check_all("r15");

    // STOP right after the first data byte
    i2c_start();
    send_byte(8'h34, 1'b0, ak);
    send_byte(8'h0E, 1'b0, ak);
    i2c_stop();
    check_all("stop_abort");
    // Repeated START in the middle of the second data byte
    i2c_start();
    send_byte(8'h34, 1'b0, ak);
    send_byte(8'h0E, 1'b0, ak);
    send_bits(8'h55, 5);
    i2c_start();
    i2c_stop();
    check_all("restart_abort");
    applyStimulus(7'd7, 9'h04A, 1'b0);
    check_all("r7");

    // Asynchronous reset in the middle of the second data byte
    applyStimulus(7'd2, 9'h1C3, 1'b0);
    i2c_start();
    send_byte(8'h34, 1'b0, ak);
    send_byte(8'h0C, 1'b0, ak);
    send_bits(8'hF0, 4);
    tb_low = 1'b0;
    reset = 1'b0;
    #3;
    checkOutput("async_busy", 32'(regs_if.busy), 32'd0);
    checkOutput("async_sda", 32'(sda === 1'b1), 32'd1);
    model_reset(); exp_addr = 7'd0; exp_data = 9'd0;
    @(negedge clk); #1;
    check_all("in_reset");
    reset = 1'b1;
    i2c_stop();
    applyStimulus(7'd5, 9'h0F1, 1'b0);
    check_all("after_reset");

    // Randomized packets at clk/16 .. clk/32
    for (int n = 0; n < 30; n++) begin
      q    = $urandom_range(4, 8);
      kind = $urandom_range(0, 5);
      a    = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      d    = 9'($urandom);
      case (kind)
        0, 1: applyStimulus(a, d, 1'b0);
        2: begin
          dev = 8'($urandom);
          if (dev == 8'h34) dev = 8'h36;
          bad_packet(dev, $urandom_range(0, 1) == 1);
        end
        3: begin
          i2c_start();
          send_byte(8'h34, 1'b0, ak);
          send_byte({a, d[8]}, 1'b0, ak);
          if ($urandom_range(0, 1) == 1) begin
            i2c_stop();
          end else begin
            send_bits(d[7:0], $urandom_range(1, 7));
            i2c_start();
            i2c_stop();
            a = 7'($urandom_range(0, 10));
            applyStimulus(a, ~d, 1'b0);
          end
        end
        4: applyStimulus(a, d, 1'b1);
        default: bad_packet(8'h35, $urandom_range(0, 1) == 1);
      endcase
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #20ms;
    fail_count++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
